// File: rtl/seq_controller.sv
// Multi-cycle sequencer for the 8-bit accumulator processor: owns the instruction
// register, steps FETCH/DECODE/EXEC/MEM/WB, and adds halt, memory watchdog and retire count.
module seq_controller #(
    parameter int COUNT_W  = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         mem_out,
    input  logic               mem_wait,
    input  logic               acc_zero,
    input  logic               halt_in,
    output logic [7:0]         ir,
    output logic               pc_we,
    output logic               brnch,
    output logic               reg_we,
    output logic               mem_we,
    output logic               lw,
    output logic               acc_we,
    output logic               acc_sc,
    output logic               mem_sc,
    output logic [1:0]         alu_ctl,
    output logic [2:0]         state,
    output logic               halted,
    output logic               wd_err,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LI   = 3'b011;
    localparam logic [2:0] OP_LA   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_SW   = 3'b110;
    localparam logic [2:0] OP_BZ   = 3'b111;

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            cur;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        op;
    logic              wait_cycle;
    logic              wd_fire;
    logic              retire;

    assign op = ir[7:5];

    // A halt request in FETCH wins over a stalled fetch, so that cycle is not a wait cycle.
    assign wait_cycle = mem_wait && ((cur == S_FETCH && !halt_in) || cur == S_MEM);
    assign wd_fire    = wait_cycle && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        retire = 1'b0;
        case (cur)
            S_EXEC:  retire = (op != OP_LW) && (op != OP_SW);
            S_MEM:   retire = (op == OP_SW) && !mem_wait;
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= S_FETCH;
            ir          <= 8'd0;
            instr_count <= '0;
            wd_err      <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (retire && (instr_count != {COUNT_W{1'b1}}))
                instr_count <= instr_count + 1'b1;

            // The state holds exactly while waiting without tripping the watchdog.
            if (wait_cycle && !wd_fire)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            case (cur)
                S_FETCH: begin
                    if (halt_in) begin
                        cur <= S_HALT;
                    end else if (!mem_wait) begin
                        ir  <= mem_out;
                        cur <= S_DECODE;
                    end else if (wd_fire) begin
                        wd_err <= 1'b1;
                        cur    <= S_HALT;
                    end
                end
                S_DECODE: cur <= S_EXEC;
                S_EXEC: begin
                    if (op == OP_LW || op == OP_SW)
                        cur <= S_MEM;
                    else
                        cur <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_wait) begin
                        if (wd_fire) begin
                            wd_err <= 1'b1;
                            cur    <= S_HALT;
                        end
                    end else if (op == OP_LW) begin
                        cur <= S_WB;
                    end else begin
                        cur <= S_FETCH;
                    end
                end
                S_WB:    cur <= S_FETCH;
                S_HALT:  cur <= S_HALT;
                default: cur <= S_HALT;
            endcase
        end
    end

    assign state  = cur;
    assign halted = (cur == S_HALT);

    always_comb begin
        pc_we   = 1'b0;
        brnch   = 1'b0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        lw      = 1'b0;
        acc_we  = 1'b0;
        acc_sc  = 1'b0;
        mem_sc  = 1'b0;
        alu_ctl = 2'b00;
        case (cur)
            S_FETCH: pc_we = !halt_in && !mem_wait;
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_NAND: begin
                        alu_ctl = op[1:0];
                        acc_we  = 1'b1;
                    end
                    OP_LI: begin
                        acc_sc = 1'b1;
                        acc_we = 1'b1;
                    end
                    OP_LA: begin
                        alu_ctl = 2'b11;
                        acc_we  = 1'b1;
                    end
                    OP_BZ: begin
                        brnch = acc_zero;
                        pc_we = acc_zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_sc = 1'b1;
                mem_we = (op == OP_SW) && !mem_wait;
            end
            S_WB: begin
                lw     = 1'b1;
                reg_we = 1'b1;
                mem_sc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
- Multi-cycle sequencer for the 8-bit accumulator processor; replaces the single-cycle control unit.
- Owns the instruction register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives all datapath enables (pc, regfile, memory, accumulator, muxes, ALU op) and tolerates a stalling memory.
- Adds halt handling, a memory-wait watchdog and a retired-instruction counter.

Parameters:
- COUNT_W, 16, width of the retired-instruction counter (saturating).
- MAX_WAIT, 15, maximum consecutive mem_wait cycles tolerated in one state before the watchdog fires.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- mem_out  input  8  memory read data; the instruction during FETCH.
- mem_wait  input  1  memory not ready this cycle; the current FETCH/MEM state holds.
- acc_zero  input  1  accumulator equals 0, used by the branch.
- halt_in  input  1  halt request, sampled in FETCH.
- ir  output  8  instruction register {opcode[7:5], immediate[4:0]}.
- pc_we  output  1  pc advance/load enable.
- brnch  output  1  pc loads the ALU result instead of incrementing.
- reg_we  output  1  register-file write enable.
- mem_we  output  1  memory write enable.
- lw  output  1  regfile input mux select: 1 = mem_out, 0 = alu_out.
- acc_we  output  1  accumulator write enable.
- acc_sc  output  1  accumulator input mux select: 1 = sign-extended immediate, 0 = regOut.
- mem_sc  output  1  memory address mux select: 1 = acc_out, 0 = pc.
- alu_ctl  output  2  ALU op: 00 add, 01 sub, 10 nand, 11 pass.
- state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- halted  output  1  high in HALT.
- wd_err  output  1  sticky watchdog error flag.
- instr_count  output  COUNT_W  retired-instruction count.

Behaviour:
- Reset: state=FETCH, ir=0, instr_count=0, wd_err=0, wait counter=0. Reset dominates every other input, including mid-instruction and in HALT.
- Outputs are decoded from state and ir. Any output not listed as asserted in a state is 0.
- FETCH:
  - mem_sc=0.
  - halt_in=1 → HALT, no fetch, pc_we=0.
  - else if mem_wait=0 → ir<=mem_out, pc_we=1, go to DECODE.
  - else hold the state with pc_we=0.
- DECODE: one cycle, no enables asserted → EXEC.
- EXEC, by opcode ir[7:5]:
  - 000 ADD, 001 SUB, 010 NAND: alu_ctl=00/01/10, acc_sc=0, acc_we=1. Retire, go to FETCH.
  - 011 LI: acc_sc=1, acc_we=1. Retire, go to FETCH.
  - 100 LA (acc<=R[imm]): alu_ctl=11, acc_sc=0, acc_we=1. Retire, go to FETCH.
  - 101 LW, 110 SW: go to MEM.
  - 111 BZ: alu_ctl=00. If acc_zero=1, brnch=1 and pc_we=1. Retire, go to FETCH.
- MEM:
  - mem_sc=1 throughout, including wait cycles.
  - SW: mem_we=1 only in the cycle where mem_wait=0; retire, go to FETCH.
  - LW: on mem_wait=0 go to WB.
- WB (LW only): lw=1, reg_we=1, mem_sc=1. Retire, go to FETCH.
- Latency without stalls:
  - ALU/LI/LA/BZ: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each mem_wait cycle adds one cycle.
- Retire means instr_count+1 on that edge; it saturates at all-ones and never wraps.
- Watchdog:
  - The wait counter increments on each mem_wait=1 cycle in FETCH or MEM and clears on any state change.
  - When a wait cycle occurs with the counter already at MAX_WAIT → wd_err<=1 and go to HALT. No write is issued and the instruction is not retired.
- HALT: absorbing until reset; all enables 0; halted=1; ir and instr_count hold.
- halt_in outside FETCH is ignored; the current instruction completes first.

Test Plan:
- Reset then mem_out=8'b011_00101 (LI 5), mem_wait=0 → states 0,1,2,0; pc_we=1 in cycle 0; acc_sc=1 and acc_we=1 in cycle 2; instr_count=1.
- LW (8'b101_00011) with mem_wait high for 2 MEM cycles → mem_sc=1 for all 3 MEM cycles; lw=1 and reg_we=1 in WB; 7 cycles total; count +1.
- SW with mem_wait=1,1,0 in MEM → mem_we pulses only on the third MEM cycle, never in the wait cycles.
- BZ (8'b111_00010): with acc_zero=1 → brnch=1 and pc_we=1 in EXEC; with acc_zero=0 → brnch=0 and pc_we=0; count increments in both cases.
- MAX_WAIT=3, mem_wait stuck high in FETCH → HALT with wd_err=1 after the 4th wait cycle; outputs stay 0; reset returns to FETCH with wd_err=0.
- halt_in=1 asserted during EXEC of ADD → ADD retires, then HALT at the next FETCH; COUNT_W=2 with 5 retirements → instr_count=3 (saturated).
